// File: rtl/axi_lite_bus_arbiter.sv
// Two-requester AXI4-Lite arbiter: fetch (m0, read-only) and mem (m1, read/write) share one downstream port.
// Optional build macro ARB_ROUND_ROBIN_EN switches read contention from fixed m1 priority to round robin.
module axi_lite_bus_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [2:0]        m0_arprot,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [31:0]       m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [2:0]        m1_arprot,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [31:0]       m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic [2:0]        m1_awprot,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    output logic [1:0]        m1_bresp,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [2:0]        s_arprot,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [31:0]       s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic [2:0]        s_awprot,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [31:0]       s_wdata,
    output logic [3:0]        s_wstrb,
    output logic              s_wvalid,
    input  logic              s_wready,
    input  logic [1:0]        s_bresp,
    input  logic              s_bvalid,
    output logic              s_bready,
    output logic              busy,
    output logic [2:0]        o_dbg_state
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_ADDR = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;

    logic [2:0] r_state, w_state_nxt;
    logic       r_gnt, w_gnt_nxt;
    logic       r_aw_done, w_aw_done_nxt;
    logic       r_w_done, w_w_done_nxt;
    logic       w_rd_req, w_rd_pick;
    logic       w_in_rd_addr, w_in_rd_data, w_in_wr_addr, w_in_wr_resp;
    logic       w_aw_hs, w_w_hs;

    assign w_rd_req = m0_arvalid | m1_arvalid;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last;

    // On contention the reader not granted last time wins; a lone request always wins.
    assign w_rd_pick = (m0_arvalid && m1_arvalid) ? ~r_last : m1_arvalid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_last <= 1'b0;
        end else if (r_state == ST_IDLE && w_rd_req) begin
            r_last <= w_rd_pick;
        end
    end
`else
    assign w_rd_pick = m1_arvalid;
`endif

    assign w_in_rd_addr = (r_state == ST_RD_ADDR);
    assign w_in_rd_data = (r_state == ST_RD_DATA);
    assign w_in_wr_addr = (r_state == ST_WR_ADDR);
    assign w_in_wr_resp = (r_state == ST_WR_RESP);

    // A handshake is valid && ready in the same cycle; outside its phase every valid/ready is held at 0.
    assign s_araddr   = r_gnt ? m1_araddr : m0_araddr;
    assign s_arprot   = r_gnt ? m1_arprot : m0_arprot;
    assign s_arvalid  = w_in_rd_addr & (r_gnt ? m1_arvalid : m0_arvalid);
    assign m0_arready = w_in_rd_addr & ~r_gnt & s_arready;
    assign m1_arready = w_in_rd_addr &  r_gnt & s_arready;

    assign s_rready   = w_in_rd_data & (r_gnt ? m1_rready : m0_rready);
    assign m0_rvalid  = w_in_rd_data & ~r_gnt & s_rvalid;
    assign m1_rvalid  = w_in_rd_data &  r_gnt & s_rvalid;
    assign m0_rdata   = s_rdata;
    assign m0_rresp   = s_rresp;
    assign m1_rdata   = s_rdata;
    assign m1_rresp   = s_rresp;

    assign s_awaddr   = m1_awaddr;
    assign s_awprot   = m1_awprot;
    assign s_awvalid  = w_in_wr_addr & m1_awvalid & ~r_aw_done;
    assign m1_awready = w_in_wr_addr & ~r_aw_done & s_awready;
    assign s_wdata    = m1_wdata;
    assign s_wstrb    = m1_wstrb;
    assign s_wvalid   = w_in_wr_addr & m1_wvalid & ~r_w_done;
    assign m1_wready  = w_in_wr_addr & ~r_w_done & s_wready;

    assign s_bready   = w_in_wr_resp & m1_bready;
    assign m1_bvalid  = w_in_wr_resp & s_bvalid;
    assign m1_bresp   = s_bresp;

    assign busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

    assign w_aw_hs = s_awvalid & s_awready;
    assign w_w_hs  = s_wvalid & s_wready;

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        case (r_state)
            ST_IDLE: begin
                // Reads are served ahead of a pending write.
                if (w_rd_req) begin
                    w_gnt_nxt   = w_rd_pick;
                    w_state_nxt = ST_RD_ADDR;
                end else if (m1_awvalid) begin
                    w_gnt_nxt   = 1'b1;
                    w_state_nxt = ST_WR_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (s_arvalid && s_arready) w_state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (s_rvalid && s_rready) w_state_nxt = ST_IDLE;
            end
            ST_WR_ADDR: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_state_nxt   = ST_WR_RESP;
                end else begin
                    w_aw_done_nxt = r_aw_done | w_aw_hs;
                    w_w_done_nxt  = r_w_done | w_w_hs;
                end
            end
            ST_WR_RESP: begin
                if (s_bvalid && s_bready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

endmodule

// File: tb/tb_axi_lite_bus_arbiter.sv
// Bench for axi_lite_bus_arbiter: directed requester tasks, a latency-programmable slave model,
// and an ordered expected-event queue checked by a monitor at the falling edge.
`timescale 1ns/1ps
module tb_axi_lite_bus_arbiter;

    localparam int EW = 40;
    localparam logic [3:0] K_AR = 4'd1;
    localparam logic [3:0] K_AW = 4'd2;
    localparam logic [3:0] K_W  = 4'd3;
    localparam logic [3:0] K_R0 = 4'd4;
    localparam logic [3:0] K_R1 = 4'd5;
    localparam logic [3:0] K_B  = 4'd6;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata, s_araddr, s_awaddr, s_wdata, s_rdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic [2:0]  m0_arprot, m1_arprot, m1_awprot, s_arprot, s_awprot, o_dbg_state;
    logic [3:0]  m1_wstrb, s_wstrb;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp, s_rresp, s_bresp;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic s_wvalid, s_wready, s_bvalid, s_bready, busy;

    axi_lite_bus_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .busy(busy), .o_dbg_state(o_dbg_state)
    );

    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];
    int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
    logic [1:0] b_resp_cfg = 2'b00;
    int m0_rv_cycles = 0, m1_rv_cycles = 0, busy_cycles = 0;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a == 32'h0000_0040) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL timeout %s: no handshake within 200 cycles, expected one", name);
    endtask

    task automatic expect_ev(input logic [3:0] k, input logic [35:0] v);
        exp_q.push_back({k, v});
    endtask

    task automatic got_ev(input string name, input logic [EW-1:0] word);
        logic [EW-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected %s: got %h, expected no event", name, word);
        end else begin
            e = exp_q.pop_front();
            if (word !== e) begin
                errors++;
                $display("FAIL event %s: got %h, expected %h", name, word, e);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {27'b0, m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
                     m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, busy}, '0);
        check({name, " state"}, {37'b0, o_dbg_state}, '0);
    endtask

    // Monitor: every handshake seen at the falling edge is matched against the head of exp_q.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (s_arvalid && s_arready) got_ev("ar", {K_AR, 4'h0, s_araddr});
                if (s_awvalid && s_awready) got_ev("aw", {K_AW, 4'h0, s_awaddr});
                if (s_wvalid && s_wready)   got_ev("w", {K_W, s_wstrb, s_wdata});
                if (m0_rvalid && m0_rready) got_ev("r0", {K_R0, 2'b0, m0_rresp, m0_rdata});
                if (m1_rvalid && m1_rready) got_ev("r1", {K_R1, 2'b0, m1_rresp, m1_rdata});
                if (m1_bvalid && m1_bready) got_ev("b", {K_B, 34'h0, m1_bresp});
                if (m0_rvalid) m0_rv_cycles++;
                if (m1_rvalid) m1_rv_cycles++;
                if (busy) busy_cycles++;
            end
        end
    end

    // Slave model: ready/valid raised after a programmable number of cycles.
    initial begin
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        logic r_pend, b_pend, aw_seen, w_seen, rst_edge;
        logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
        logic [31:0] ar_addr_l;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_awready = 0;
        s_wready = 0; s_bvalid = 0; s_bresp = '0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_addr_l = '0;
        forever begin
            @(posedge clk);
            rst_edge = !rstn;
            #2;
            if (rst_edge) begin
                r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
                s_arready = 0; s_rvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 0;
            end else begin
                if (r_hs) r_pend = 0;
                if (ar_hs) begin
                    r_pend = 1; r_cnt = 0; s_rdata = rd_model(ar_addr_l); s_rresp = 2'b00;
                end
                if (s_arvalid) begin s_arready = (ar_cnt >= ar_lat); ar_cnt++; end
                else begin s_arready = 0; ar_cnt = 0; end
                if (r_pend) begin s_rvalid = (r_cnt >= r_lat); r_cnt++; end
                else s_rvalid = 0;
                if (s_awvalid) begin s_awready = (aw_cnt >= aw_lat); aw_cnt++; end
                else begin s_awready = 0; aw_cnt = 0; end
                if (s_wvalid) begin s_wready = (w_cnt >= w_lat); w_cnt++; end
                else begin s_wready = 0; w_cnt = 0; end
                if (b_hs) b_pend = 0;
                if (aw_hs) aw_seen = 1;
                if (w_hs) w_seen = 1;
                if (aw_seen && w_seen) begin
                    b_pend = 1; b_cnt = 0; aw_seen = 0; w_seen = 0; s_bresp = b_resp_cfg;
                end
                if (b_pend) begin s_bvalid = (b_cnt >= b_lat); b_cnt++; end
                else s_bvalid = 0;
            end
            #1;
            ar_hs = rstn && s_arvalid && s_arready;
            ar_addr_l = s_araddr;
            r_hs  = rstn && s_rvalid && s_rready;
            aw_hs = rstn && s_awvalid && s_awready;
            w_hs  = rstn && s_wvalid && s_wready;
            b_hs  = rstn && s_bvalid && s_bready;
        end
    end

    task automatic m0_read(input logic [31:0] a);
        int t;
        @(posedge clk); #1;
        m0_araddr = a; m0_arprot = 3'b100; m0_arvalid = 1;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (m0_arready) break;
            t++;
            if (t > 200) begin timeout_fail("m0 ar"); break; end
        end
        @(posedge clk); #1;
        m0_arvalid = 0;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (m0_rvalid) break;
            t++;
            if (t > 200) begin timeout_fail("m0 r"); break; end
        end
        @(posedge clk);
    endtask

    task automatic m1_read(input logic [31:0] a);
        int t;
        @(posedge clk); #1;
        m1_araddr = a; m1_arprot = 3'b000; m1_arvalid = 1;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (m1_arready) break;
            t++;
            if (t > 200) begin timeout_fail("m1 ar"); break; end
        end
        @(posedge clk); #1;
        m1_arvalid = 0;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (m1_rvalid) break;
            t++;
            if (t > 200) begin timeout_fail("m1 r"); break; end
        end
        @(posedge clk);
    endtask

    task automatic m1_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
        int t;
        logic aw_ok, w_ok, aw_now, w_now;
        @(posedge clk); #1;
        m1_awaddr = a; m1_awprot = 3'b000; m1_awvalid = 1;
        m1_wdata = d; m1_wstrb = strb; m1_wvalid = 1;
        aw_ok = 0; w_ok = 0; t = 0;
        while (!(aw_ok && w_ok)) begin
            @(negedge clk);
            aw_now = m1_awvalid && m1_awready;
            w_now  = m1_wvalid && m1_wready;
            @(posedge clk); #1;
            if (aw_now) begin aw_ok = 1; m1_awvalid = 0; end
            if (w_now) begin w_ok = 1; m1_wvalid = 0; end
            t++;
            if (t > 200) begin timeout_fail("m1 aw/w"); m1_awvalid = 0; m1_wvalid = 0; break; end
        end
        t = 0;
        while (1) begin
            @(negedge clk);
            if (m1_bvalid) break;
            t++;
            if (t > 200) begin timeout_fail("m1 b"); break; end
        end
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m0_araddr = '0; m0_arprot = '0; m0_arvalid = 0; m0_rready = 1;
        m1_araddr = '0; m1_arprot = '0; m1_arvalid = 0; m1_rready = 1;
        m1_awaddr = '0; m1_awprot = '0; m1_awvalid = 0;
        m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset idle");
        @(posedge clk); #1;
        rstn = 1;
        repeat (2) @(posedge clk);

        // Lone fetch read, slave AR and R each one cycle late
        ar_lat = 1; r_lat = 1;
        m0_rv_cycles = 0; m1_rv_cycles = 0; busy_cycles = 0;
        expect_ev(K_AR, {4'h0, 32'h0000_0040});
        expect_ev(K_R0, {4'h0, 32'hDEAD_BEEF});
        m0_read(32'h0000_0040);
        // Two RD_ADDR cycles plus two RD_DATA cycles; the arbitration cycle is IDLE.
        check("busy cycles", EW'(busy_cycles), EW'(4));
        check("m1 rvalid cycles", EW'(m1_rv_cycles), EW'(0));
        check("m0 rvalid cycles", EW'(m0_rv_cycles), EW'(1));
        repeat (2) @(posedge clk);

        // Read contention, repeated: m1 wins, then m0 each time in both builds
        ar_lat = 0; r_lat = 0;
        for (int i = 0; i < 4; i++) begin
            expect_ev(K_AR, {4'h0, 32'h8000_0000});
            expect_ev(K_R1, {4'h0, 32'h25A5_0000});
            expect_ev(K_AR, {4'h0, 32'h0000_0100});
            expect_ev(K_R0, {4'h0, 32'hA5A5_0100});
            fork
                m0_read(32'h0000_0100);
                m1_read(32'h8000_0000);
            join
            @(posedge clk);
        end

        // Write with W accepted two cycles before AW
        aw_lat = 2; w_lat = 0; b_lat = 0; b_resp_cfg = 2'b00;
        expect_ev(K_W, {4'hF, 32'h1234_5678});
        expect_ev(K_AW, {4'h0, 32'h8000_0004});
        expect_ev(K_B, 36'h0);
        m1_write(32'h8000_0004, 32'h1234_5678, 4'hF);
        repeat (2) @(posedge clk);

        // Write and read raised together: read first; SLVERR bresp forwarded unchanged
        aw_lat = 0; b_lat = 1; b_resp_cfg = 2'b10;
        expect_ev(K_AR, {4'h0, 32'h0000_0200});
        expect_ev(K_R0, {4'h0, 32'hA5A5_0200});
        expect_ev(K_AW, {4'h0, 32'h8000_0008});
        expect_ev(K_W, {4'h3, 32'hCAFE_F00D});
        expect_ev(K_B, {34'h0, 2'b10});
        fork
            m0_read(32'h0000_0200);
            m1_write(32'h8000_0008, 32'hCAFE_F00D, 4'h3);
        join
        repeat (2) @(posedge clk);

        // Reset while in RD_DATA, then a fresh read
        ar_lat = 0; r_lat = 20; b_lat = 0; b_resp_cfg = 2'b00;
        expect_ev(K_AR, {4'h0, 32'h0000_0300});
        @(posedge clk); #1;
        m0_araddr = 32'h0000_0300; m0_arvalid = 1;
        begin
            int t;
            t = 0;
            while (1) begin
                @(negedge clk);
                if (m0_arready) break;
                t++;
                if (t > 200) begin timeout_fail("reset-test ar"); break; end
            end
        end
        @(posedge clk); #1;
        m0_arvalid = 0;
        @(negedge clk);
        check("pre-reset state", {37'b0, o_dbg_state}, EW'(2));
        @(posedge clk); #1;
        rstn = 0;
        @(posedge clk); #1;
        rstn = 1;
        @(negedge clk);
        check_idle_outputs("mid-read reset");
        r_lat = 0;
        expect_ev(K_AR, {4'h0, 32'h0000_0040});
        expect_ev(K_R0, {4'h0, 32'hDEAD_BEEF});
        m0_read(32'h0000_0040);

        repeat (5) @(posedge clk);
        check("queue drained", EW'(exp_q.size()), EW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
